// File: rtl/sat_add_arb.sv
// sat_add_arb: two-port round-robin arbiter in front of a single 16-bit
// overflow-detecting adder. A grant is combinational in the request cycle,
// and the result, flags and per-port valid pulse appear one edge later.
// A running 8-bit saturating count of overflowed adds is kept alongside.

module sat_add_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        hold,
    input  logic        clr_cnt,
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] out,
    output logic        zr,
    output logic        neg,
    output logic        ov,
    output logic        vld0,
    output logic        vld1,
    output logic [7:0]  ovf_cnt
);

    localparam int        NP      = 2;
    localparam int        W       = 16;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Overflow results are reported on fixed rails: an overflow of two
    // non-negative operands reports 16'h8000, an overflow of two negative
    // operands reports 16'h7FFF.
    localparam logic [W-1:0] RAIL_POS_OVF = 16'h8000;
    localparam logic [W-1:0] RAIL_NEG_OVF = 16'h7FFF;

    // ------------------------------------------------------------------
    // Per-port request and operand vectors
    // ------------------------------------------------------------------
    logic [NP-1:0] req_vec;
    logic [W-1:0]  a_vec  [NP];
    logic [W-1:0]  b_vec  [NP];
    logic [W-1:0]  a_term [NP];
    logic [W-1:0]  b_term [NP];

    assign req_vec  = {req1, req0};
    assign a_vec[0] = a0;
    assign a_vec[1] = a1;
    assign b_vec[0] = b0;
    assign b_vec[1] = b1;

    // ------------------------------------------------------------------
    // Arbitration state and grant
    // ------------------------------------------------------------------
    // last_reg holds the id of the most recently granted port; after reset
    // it points at port 1 so that port 0 wins the first contention.
    logic          last_reg;
    logic [NP-1:0] gnt_vec;
    logic          grant_any;
    logic          grant_id;

    // Round-robin grant: contention goes to the port that was not last,
    // a lone request is granted directly, reset and hold suppress grants.
    always_comb begin
        gnt_vec = '0;
        if (!rst && !hold) begin
            if (req_vec == 2'b11) begin
                gnt_vec = last_reg ? 2'b01 : 2'b10;
            end else begin
                gnt_vec = req_vec;
            end
        end
    end

    assign grant_any = |gnt_vec;
    assign grant_id  = gnt_vec[1];
    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];

    // ------------------------------------------------------------------
    // Operand selection: one-hot grant makes an AND-OR mux sufficient
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            assign a_term[gi] = a_vec[gi] & {W{gnt_vec[gi]}};
            assign b_term[gi] = b_vec[gi] & {W{gnt_vec[gi]}};
        end
    endgenerate

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    assign op_a = a_term[0] | a_term[1];
    assign op_b = b_term[0] | b_term[1];

    // ------------------------------------------------------------------
    // Adder with overflow detection and rail substitution
    // ------------------------------------------------------------------
    logic [W-1:0] sum_raw;
    logic         ovf_pos;
    logic         ovf_neg;
    logic [W-1:0] res_next;
    logic         zr_next;
    logic         neg_next;
    logic         ov_next;

    // Modulo-2^16 sum; overflow is a sign flip with equal operand signs.
    always_comb begin
        sum_raw  = op_a + op_b;
        ovf_pos  = ~op_a[W-1] & ~op_b[W-1] &  sum_raw[W-1];
        ovf_neg  =  op_a[W-1] &  op_b[W-1] & ~sum_raw[W-1];
        res_next = sum_raw;
        zr_next  = (sum_raw == '0);
        neg_next = sum_raw[W-1];
        ov_next  = 1'b0;
        if (ovf_pos) begin
            res_next = RAIL_POS_OVF;
            zr_next  = 1'b0;
            neg_next = 1'b1;
            ov_next  = 1'b1;
        end else if (ovf_neg) begin
            res_next = RAIL_NEG_OVF;
            zr_next  = 1'b0;
            neg_next = 1'b0;
            ov_next  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic [W-1:0]  out_reg;
    logic          zr_reg;
    logic          neg_reg;
    logic          ov_reg;
    logic [NP-1:0] vld_reg;

    // Pointer update: the granted id becomes the new last.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (grant_any) begin
            last_reg <= grant_id;
        end
    end

    // Result and flags load on a granted edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
            zr_reg  <= 1'b0;
            neg_reg <= 1'b0;
            ov_reg  <= 1'b0;
        end else if (grant_any) begin
            out_reg <= res_next;
            zr_reg  <= zr_next;
            neg_reg <= neg_next;
            ov_reg  <= ov_next;
        end
    end

    // Valid pulse tags the result with the id it was granted to.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= gnt_vec;
        end
    end

    // ------------------------------------------------------------------
    // Overflow counter
    // ------------------------------------------------------------------
    logic [7:0] ovf_cnt_reg;
    logic [7:0] ovf_cnt_next;

    // Clear beats a coincident overflow; counting stops at CNT_MAX.
    always_comb begin
        ovf_cnt_next = ovf_cnt_reg;
        if (clr_cnt) begin
            ovf_cnt_next = '0;
        end else if (grant_any && ov_next && (ovf_cnt_reg != CNT_MAX)) begin
            ovf_cnt_next = ovf_cnt_reg + 8'd1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_reg <= '0;
        end else begin
            ovf_cnt_reg <= ovf_cnt_next;
        end
    end

    assign out     = out_reg;
    assign zr      = zr_reg;
    assign neg     = neg_reg;
    assign ov      = ov_reg;
    assign vld0    = vld_reg[0];
    assign vld1    = vld_reg[1];
    assign ovf_cnt = ovf_cnt_reg;

endmodule

// File: tb/tb_sat_add_arb.sv
// Bench for sat_add_arb: directed scenarios followed by randomized traffic,
// every cycle compared against an integer-arithmetic reference model.

module tb_sat_add_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        hold, clr_cnt;
    logic        gnt0, gnt1;
    logic [15:0] out;
    logic        zr, neg, ov, vld0, vld1;
    logic [7:0]  ovf_cnt;

    sat_add_arb dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .hold    (hold),
        .clr_cnt (clr_cnt),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .out     (out),
        .zr      (zr),
        .neg     (neg),
        .ov      (ov),
        .vld0    (vld0),
        .vld1    (vld1),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [15:0] m_out;
    logic        m_zr, m_neg, m_ov, m_vld0, m_vld1;
    int          m_cnt;
    int          m_last;
    int          m_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // one clock cycle: drive, check grant mid-cycle, advance model, check outputs
    task automatic cycle(input logic r, input logic q0, input logic q1,
                         input logic [15:0] xa0, input logic [15:0] xb0,
                         input logic [15:0] xa1, input logic [15:0] xb1,
                         input logic h, input logic c, input string note);
        int g, sa, sb, s;
        logic [15:0] oa, ob;
        rst = r; req0 = q0; req1 = q1;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        hold = h; clr_cnt = c;
        @(negedge clk);
        g = -1;
        if (!r && !h) begin
            if (q0 && q1)  g = (m_last == 1) ? 0 : 1;
            else if (q0)   g = 0;
            else if (q1)   g = 1;
        end
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        @(posedge clk);
        m_g = g;
        if (r) begin
            m_out = 16'h0000; m_zr = 0; m_neg = 0; m_ov = 0;
            m_vld0 = 0; m_vld1 = 0; m_cnt = 0; m_last = 1;
        end else begin
            m_vld0 = (g == 0);
            m_vld1 = (g == 1);
            if (g >= 0) begin
                oa = (g == 0) ? xa0 : xa1;
                ob = (g == 0) ? xb0 : xb1;
                sa = $signed(oa);
                sb = $signed(ob);
                s  = sa + sb;
                if (s > 32767) begin
                    m_out = 16'h8000; m_ov = 1; m_neg = 1; m_zr = 0;
                end else if (s < -32768) begin
                    m_out = 16'h7FFF; m_ov = 1; m_neg = 0; m_zr = 0;
                end else begin
                    m_out = 16'(s); m_ov = 0; m_neg = (s < 0); m_zr = (s == 0);
                end
                m_last = g;
            end
            if (c)                                   m_cnt = 0;
            else if (g >= 0 && m_ov && m_cnt < 255)  m_cnt = m_cnt + 1;
        end
        #1;
        chk("out",     32'(out),     32'(m_out));
        chk("zr",      32'(zr),      32'(m_zr));
        chk("neg",     32'(neg),     32'(m_neg));
        chk("ov",      32'(ov),      32'(m_ov));
        chk("vld0",    32'(vld0),    32'(m_vld0));
        chk("vld1",    32'(vld1),    32'(m_vld1));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
        $display("cyc %0d %s rst=%b req=%b%b hold=%b clr=%b gnt=%0d out=%h zr=%b neg=%b ov=%b vld=%b%b cnt=%0d",
                 cyc, note, r, q0, q1, h, c, g, out, zr, neg, ov, vld0, vld1, ovf_cnt);
        cyc++;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom % 5)
            0:       rnd16 = 16'h7FFF - 16'($urandom % 4);
            1:       rnd16 = 16'h8000 + 16'($urandom % 4);
            2:       rnd16 = 16'($urandom % 8);
            3:       rnd16 = 16'hFFFF - 16'($urandom % 8);
            default: rnd16 = 16'($urandom);
        endcase
    endfunction

    initial begin
        logic        sr0, sr1, h, c, r;
        logic [15:0] sa0, sb0, sa1, sb1;

        rst = 1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        hold = 0; clr_cnt = 0;
        m_out = 0; m_zr = 0; m_neg = 0; m_ov = 0; m_vld0 = 0; m_vld1 = 0;
        m_cnt = 0; m_last = 1; m_g = -1;

        // reset with requests asserted: no grants, outputs cleared
        cycle(1, 1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, "reset");
        cycle(1, 1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, "reset");

        // basic adds and both overflow rails
        cycle(0, 1, 0, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 0, 0, "add3+4");
        cycle(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "idle");
        cycle(0, 1, 0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 0, 0, "posovf");
        cycle(0, 0, 1, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 0, 0, "negovf");
        cycle(0, 1, 0, 16'h0005, 16'hFFFB, 16'h0000, 16'h0000, 0, 0, "zero");
        cycle(0, 0, 1, 16'h0000, 16'h0000, 16'hFFF0, 16'h0001, 0, 0, "negres");

        // fresh reset, then contention: port 0 first, then alternate
        cycle(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "reset");
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 1, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 0, 0, "rr");

        // hold blocks grants and freezes results; release grants not-last
        cycle(0, 1, 1, 16'h0100, 16'h0001, 16'h0200, 16'h0002, 1, 0, "hold");
        cycle(0, 1, 1, 16'h0100, 16'h0001, 16'h0200, 16'h0002, 1, 0, "hold");
        cycle(0, 1, 1, 16'h0100, 16'h0001, 16'h0200, 16'h0002, 0, 0, "release");

        // add granted just before reset is discarded
        cycle(0, 0, 1, 16'h0000, 16'h0000, 16'h7000, 16'h7000, 0, 0, "preRst");
        cycle(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "reset");
        cycle(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, "idle");

        // counter saturation and clear-wins-over-overflow
        for (int i = 0; i < 258; i++)
            cycle(0, 1, 0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, "ovfrun");
        cycle(0, 1, 0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 0, 1, "clr+ovf");
        cycle(0, 0, 1, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 0, 0, "ovf");

        // randomized traffic; operands stay put while a request is pending
        sr0 = 0; sr1 = 0; sa0 = 0; sb0 = 0; sa1 = 0; sb1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!sr0 || m_g == 0) begin
                sr0 = ($urandom % 3) != 0; sa0 = rnd16(); sb0 = rnd16();
            end else if ($urandom % 16 == 0) begin
                sr0 = 0;
            end
            if (!sr1 || m_g == 1) begin
                sr1 = ($urandom % 3) != 0; sa1 = rnd16(); sb1 = rnd16();
            end else if ($urandom % 16 == 0) begin
                sr1 = 0;
            end
            h = ($urandom % 5) == 0;
            c = !h && (($urandom % 20) == 0);
            r = ($urandom % 100) == 0;
            cycle(r, sr0, sr1, sa0, sb0, sa1, sb1, h, c, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
